// File: rtl/cpu_types_pkg.sv
// Shared types for the coherence bus: word type, bus state encoding and default port count.
package cpu_types_pkg;

    localparam int unsigned CPUS_DEFAULT   = 2;
    localparam int unsigned WORD_W_DEFAULT = 32;

    typedef logic [WORD_W_DEFAULT-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SNOOP,
        OWNER_WB,
        MEM_RD,
        MEM_WB,
        DONE
    } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after the last grant, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          valid_o
);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_oh_o[idx]  = 1'b1;
                gnt_idx_o      = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/coherence_bus_rr.sv
// Snooping coherence bus serving one cache transaction at a time with round-robin arbitration.
// Define CC_CACHE_TO_CACHE_EN to forward owner write-back data straight to the reader.
module coherence_bus_rr
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS   = CPUS_DEFAULT,
    parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS*WORD_W-1:0] dload,
    output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramwait
);

    localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;

    bus_state_t        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic [CPUS-1:0]   req;
    logic [CPUS-1:0]   arb_oh;
    logic [IW-1:0]     arb_idx;
    logic              arb_valid;
    logic              snoop_hit;
    logic [IW-1:0]     snoop_idx;
    logic [WORD_W-1:0] daddr_g, dstore_g, daddr_o, dstore_o;

    assign req      = dREN | dWEN | ccwrite;
    assign daddr_g  = daddr[grant_q*WORD_W +: WORD_W];
    assign dstore_g = dstore[grant_q*WORD_W +: WORD_W];
    assign daddr_o  = daddr[owner_q*WORD_W +: WORD_W];
    assign dstore_o = dstore[owner_q*WORD_W +: WORD_W];

    rr_arbiter #(
        .N  (CPUS),
        .IW (IW)
    ) u_arb (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .valid_o   (arb_valid)
    );

    // Lowest-numbered other cache holding the line modified becomes the owner.
    always_comb begin
        snoop_hit = 1'b0;
        snoop_idx = '0;
        for (int unsigned j = 0; j < CPUS; j++) begin
            if (!snoop_hit && cctrans[j] && (IW'(j) != grant_q)) begin
                snoop_hit = 1'b1;
                snoop_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rdata_d     = rdata_q;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        dload       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state_q)
            IDLE: begin
                if (|req) state_d = ARB;
            end
            ARB: begin
                ccwait = ~arb_oh;
                if (arb_valid) begin
                    grant_d = arb_idx;
                    if (dWEN[arb_idx] && !dREN[arb_idx] && !ccwrite[arb_idx])
                        state_d = MEM_WB;
                    else
                        state_d = SNOOP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                ccwait          = '1;
                ccwait[grant_q] = 1'b0;
                // A requester that gives up mid-transaction leaves no strobe or handshake behind.
                if (!req[grant_q]) begin
                    state_d = IDLE;
                end else begin
                    case (state_q)
                        SNOOP: begin
                            ccsnoopaddr = {CPUS{daddr_g}};
                            if (snoop_hit) begin
                                owner_d = snoop_idx;
                                state_d = OWNER_WB;
                            end else if (dREN[grant_q]) begin
                                state_d = MEM_RD;
                            end else begin
                                ccinv          = '1;
                                ccinv[grant_q] = 1'b0;
                                dwait[grant_q] = 1'b0;
                                state_d        = IDLE;
                            end
                        end
                        OWNER_WB: begin
                            ramWEN   = 1'b1;
                            ramaddr  = daddr_o;
                            ramstore = dstore_o;
                            if (!ramwait) begin
                                dwait[owner_q] = 1'b0;
                                ccinv[owner_q] = ccwrite[grant_q];
                                if (dREN[grant_q]) begin
`ifdef CC_CACHE_TO_CACHE_EN
                                    dload[grant_q*WORD_W +: WORD_W] = dstore_o;
                                    dwait[grant_q]                  = 1'b0;
                                    state_d                         = IDLE;
`else
                                    state_d = MEM_RD;
`endif
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                        end
                        MEM_RD: begin
                            ramREN  = 1'b1;
                            ramaddr = daddr_g;
                            if (!ramwait) begin
                                rdata_d = ramload;
                                state_d = DONE;
                            end
                        end
                        DONE: begin
                            dwait[grant_q]                  = 1'b0;
                            dload[grant_q*WORD_W +: WORD_W] = rdata_q;
                            ccinv                           = {CPUS{ccwrite[grant_q]}};
                            ccinv[grant_q]                  = 1'b0;
                            state_d                         = IDLE;
                        end
                        MEM_WB: begin
                            ramWEN   = 1'b1;
                            ramaddr  = daddr_g;
                            ramstore = dstore_g;
                            if (!ramwait) begin
                                dwait[grant_q] = 1'b0;
                                state_d        = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        if (state_d == IDLE && state_q != IDLE && state_q != ARB) last_d = grant_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(CPUS - 1);
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_coherence_bus_rr.sv
// Directed bench for coherence_bus_rr (CPUS=4) with a transaction-level reference model.
module tb_coherence_bus_rr;

    localparam int N = 4;
    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   dREN = '0, dWEN = '0, ccwrite = '0, cctrans = '0;
    logic [N*W-1:0] daddr = '0, dstore = '0;
    logic [N-1:0]   dwait, ccwait, ccinv;
    logic [N*W-1:0] dload, ccsnoopaddr;
    logic           ramREN, ramWEN;
    logic [W-1:0]   ramaddr, ramstore;
    logic [W-1:0]   ramload = '0;
    logic           ramwait = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int                   m_last  = N - 1;
    int                   m_grant = -1;
    bit                   m_busy  = 1'b0;
    cpu_types_pkg::word_t m_expload = '0;

    int                   n_ren = 0, n_wen = 0;
    cpu_types_pkg::word_t wen_addr = '0, wen_data = '0;
    int                   done_q[$];

    coherence_bus_rr #(.CPUS(N), .WORD_W(W)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
        .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
        .dload(dload), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Reference model: a transaction owns the bus from grant until the bus is idle again,
    // and the served port becomes the round-robin pointer.
    always @(negedge CLK) begin
        logic [N*W-1:0] masked;
        logic [N-1:0]   e;
        if (RST) begin
            m_last  = N - 1;
            m_busy  = 1'b0;
            m_grant = -1;
        end else begin
            if (ccwait == '0) begin
                if (m_busy) begin
                    m_last = m_grant;
                    m_busy = 1'b0;
                end
                m_grant = rr_pick(dREN | dWEN | ccwrite, m_last);
            end else begin
                m_busy = 1'b1;
            end
            chk("ram_excl", ramREN & ramWEN, 0);
            masked = '0;
            for (int i = 0; i < N; i++)
                if (dwait[i]) masked[i*W +: W] = dload[i*W +: W];
            chk("dload_idle", masked, 0);
            if (ramREN) n_ren++;
            if (ramWEN) begin
                n_wen++;
                wen_addr = ramaddr;
                wen_data = ramstore;
            end
            if (ccwait != '0 && m_grant >= 0) begin
                e = ~(N'(1) << m_grant);
                chk("ccwait_grant", ccwait, e);
                if (ramREN) chk("ramaddr_rd", ramaddr, daddr[m_grant*W +: W]);
                if (!dwait[m_grant]) begin
                    done_q.push_back(m_grant);
                    chk("dload_grant", dload[m_grant*W +: W], m_expload);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        n_ren = 0;
        n_wen = 0;
        done_q.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; ramwait = 1'b0;
        @(negedge CLK);
        chk("rst_dwait", dwait, 4'hF);
        chk("rst_ccwait", ccwait, 0);
        chk("rst_ccinv", ccinv, 0);
        chk("rst_ram", {ramREN, ramWEN}, 0);
        chk("rst_dload", dload, 0);
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_done(input int port, input int bound, output int cyc,
                             output logic [W-1:0] ld, output logic [N-1:0] cw,
                             output logic [N-1:0] ci, output logic [N*W-1:0] sa);
        cyc = -1; ld = '0; cw = '0; ci = '0; sa = '0;
        for (int n = 0; n < bound && cyc < 0; n++) begin
            @(negedge CLK);
            if (!dwait[port]) begin
                cyc = n;
                ld  = dload[port*W +: W];
                cw  = ccwait;
                ci  = ccinv;
                sa  = ccsnoopaddr;
            end
            tick();
        end
        chk("done_seen", cyc >= 0, 1);
    endtask

    initial begin
        int             cyc, wc, drop;
        bit             found;
        logic [W-1:0]   ld;
        logic [N-1:0]   cw, ci;
        logic [N*W-1:0] sa;
        int             exp_rr[4];

        tick();
        do_reset();

        // single read miss on port 1
        clr();
        daddr[1*W +: W] = 32'h0000_0100;
        ramload = 32'hCAFE_0001; m_expload = 32'hCAFE_0001; ramwait = 1'b0;
        dREN = 4'b0010;
        wait_done(1, 20, cyc, ld, cw, ci, sa);
        dREN = '0;
        chk("rd_latency", cyc, 4);
        chk("rd_dload", ld, 32'hCAFE_0001);
        chk("rd_ccwait", cw, 4'b1101);
        chk("rd_ren_cycles", n_ren, 1);
        chk("rd_wen_cycles", n_wen, 0);

        // requester abandons during MEM_RD
        clr();
        daddr[0*W +: W] = 32'h0000_6000; ramwait = 1'b1; m_expload = '0;
        dREN = 4'b0001;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge CLK);
            if (ramREN) found = 1'b1;
            tick();
        end
        chk("abort_rd_seen", found, 1);
        dREN = '0;
        @(negedge CLK);
        chk("abort_ren", ramREN, 0);
        chk("abort_dwait", dwait, 4'hF);
        tick();
        @(negedge CLK);
        chk("abort_idle", {ccwait, ramREN}, 0);
        tick();
        ramwait = 1'b0;

        // after abandon the pointer sits on port 0, so port 1 beats port 3
        clr();
        daddr[1*W +: W] = 32'h0000_7100; daddr[3*W +: W] = 32'h0000_7300;
        ramload = 32'h1111_0001; m_expload = 32'h1111_0001;
        dREN = 4'b1010;
        for (int n = 0; n < 20 && done_q.size() == 0; n++) tick();
        chk("last_after_abort", (done_q.size() > 0) ? done_q[0] : -1, 1);
        dREN = '0;
        tick();

        // held reads on ports 0,2,3 rotate with wrap
        do_reset();
        clr();
        daddr[0*W +: W] = 32'h0000_A000; daddr[2*W +: W] = 32'h0000_A200;
        daddr[3*W +: W] = 32'h0000_A300;
        ramload = 32'h55AA_0000; m_expload = 32'h55AA_0000;
        dREN = 4'b1101;
        for (int n = 0; n < 80 && done_q.size() < 4; n++) tick();
        dREN = '0;
        exp_rr = '{0, 2, 3, 0};
        chk("rr_count", done_q.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < done_q.size()) chk("rr_order", done_q[k], exp_rr[k]);
        chk("rr_ren_cycles", n_ren, 4);
        tick();

        // read hits a modified line in port 1
        do_reset();
        clr();
        daddr[0*W +: W] = 32'h0000_2004; daddr[1*W +: W] = 32'h0000_2000;
        dstore[1*W +: W] = 32'h1234_5678;
        ramload = 32'h0BAD_0002;
`ifdef CC_CACHE_TO_CACHE_EN
        m_expload = 32'h1234_5678;
`else
        m_expload = 32'h0BAD_0002;
`endif
        cctrans = 4'b0010;
        dREN = 4'b0001;
        wait_done(0, 20, cyc, ld, cw, ci, sa);
        dREN = '0; cctrans = '0;
        chk("own_wen_cycles", n_wen, 1);
        chk("own_wen_addr", wen_addr, 32'h0000_2000);
        chk("own_wen_data", wen_data, 32'h1234_5678);
`ifdef CC_CACHE_TO_CACHE_EN
        chk("own_ren_cycles", n_ren, 0);
        chk("own_latency", cyc, 3);
        chk("own_dload", ld, 32'h1234_5678);
`else
        chk("own_ren_cycles", n_ren, 1);
        chk("own_latency", cyc, 5);
        chk("own_dload", ld, 32'h0BAD_0002);
`endif
        tick();

        // invalidate-only request from port 2
        do_reset();
        clr();
        daddr[2*W +: W] = 32'h0000_4000; m_expload = '0;
        ccwrite = 4'b0100;
        wait_done(2, 20, cyc, ld, cw, ci, sa);
        ccwrite = '0;
        chk("inv_latency", cyc, 2);
        chk("inv_ccinv", ci, 4'b1011);
        chk("inv_snoopaddr", sa, {4{32'h0000_4000}});
        chk("inv_mem_cycles", n_ren + n_wen, 0);
        tick();

        // write-back stalled three cycles by memory
        do_reset();
        clr();
        daddr[0*W +: W] = 32'h0000_3000; dstore[0*W +: W] = 32'hDEAD_BEEF;
        ramwait = 1'b1; m_expload = '0;
        dWEN = 4'b0001;
        wc = 0; drop = -1;
        for (int n = 0; n < 20 && drop < 0; n++) begin
            @(negedge CLK);
            if (ramWEN) wc++;
            if (!dwait[0]) drop = wc;
            tick();
            if (wc >= 3) ramwait = 1'b0;
        end
        dWEN = '0;
        chk("wb_drop_cycle", drop, 4);
        chk("wb_wen_cycles", n_wen, 4);
        chk("wb_addr", wen_addr, 32'h0000_3000);
        chk("wb_data", wen_data, 32'hDEAD_BEEF);
        chk("wb_ren_cycles", n_ren, 0);
        tick();

        // reset lands in the middle of a stalled memory read
        do_reset();
        clr();
        daddr[3*W +: W] = 32'h0000_5000; ramwait = 1'b1;
        dREN = 4'b1000;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge CLK);
            if (ramREN) found = 1'b1;
            else tick();
        end
        chk("mid_rd_seen", found, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_ren", ramREN, 0);
        chk("mid_rst_dwait", dwait, 4'hF);
        chk("mid_rst_ccwait", ccwait, 0);
        tick();
        dREN = '0; RST = 1'b0; ramwait = 1'b0;
        @(negedge CLK);
        chk("post_rst_idle", {ramREN, ramWEN, ccwait}, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
